// File: rtl/kadai4_pkg.sv
// kadai4_pkg: shared types and widths for the sequential 8x8 multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kadai4_pkg;

  localparam int OPW   = 8;   // operand width
  localparam int RESW  = 16;  // product width
  localparam int ITERS = 8;   // shift-add iterations per product
  localparam int CNTW  = 4;   // iteration counter width, holds 0..ITERS

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_CALC,
    ST_OUT
  } state_t;

endpackage

// File: rtl/kadai4_mul8.sv
// kadai4_mul8: shift-add datapath (multiplicand, multiplier, accumulator, counter).
// Latency: one iteration per i_step; o_done rises once ITERS steps have been taken.
// Backpressure: none; the controller decides when to load, step or clear.
// Ports: i_clk/i_rst clock and sync reset; i_load captures i_a/i_b and zeroes
//        acc/counter; i_step runs one iteration; i_clear zeroes acc/counter;
//        o_acc running product; o_done counter reached ITERS.
module kadai4_mul8
  import kadai4_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_clear,
  input  logic [OPW-1:0]  i_a,
  input  logic [OPW-1:0]  i_b,
  output logic [RESW-1:0] o_acc,
  output logic            o_done
);

  logic [OPW-1:0]  r_mcand;
  logic [OPW-1:0]  r_mplier;
  logic [RESW-1:0] r_acc;
  logic [CNTW-1:0] r_cnt;

  // Multiplicand weighted by the current bit position; the multiplier is
  // shifted right so its LSB is always the bit for this position.
  logic [RESW-1:0] w_partial;
  assign w_partial = RESW'(r_mcand) << r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_step) begin
      if (r_mplier[0])
        r_acc <= r_acc + w_partial;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNTW'(1);
    end
  end

  assign o_acc  = r_acc;
  assign o_done = (r_cnt == CNTW'(ITERS));

endmodule

// File: rtl/kadai4.sv
// kadai4: continuous 8x8 unsigned multiplier with REQ_AB/ACK operand handshake.
// Latency: X/X_VALID 9 edges after the ACK capture edge; 10 cycles per product plus ACK wait.
// Backpressure: REQ_AB held until ACK; HALT aborts to IDLE, RST clears everything.
// Ports: CLK, RST (sync, active-high), START, HALT, A, B, ACK in;
//        REQ_AB, X (last product), X_VALID (one-cycle strobe) out, all registered.
module kadai4
  import kadai4_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            HALT,
  input  logic [OPW-1:0]  A,
  input  logic [OPW-1:0]  B,
  input  logic            ACK,
  output logic            REQ_AB,
  output logic [RESW-1:0] X,
  output logic            X_VALID
);

  state_t          r_state;
  logic            r_req_ab;
  logic [RESW-1:0] r_x;
  logic            r_x_valid;

  logic [RESW-1:0] w_acc;
  logic            w_done;
  logic            w_load;
  logic            w_step;
  logic            w_clear;

  // HALT suppresses operand capture and iteration on the same edge it wins.
  assign w_load  = (r_state == ST_REQ)  && ACK && !HALT;
  assign w_step  = (r_state == ST_CALC) && !w_done && !HALT;
  assign w_clear = HALT;

  kadai4_mul8 u_mul8 (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_clear (w_clear),
    .i_a     (A),
    .i_b     (B),
    .o_acc   (w_acc),
    .o_done  (w_done)
  );

  // Outputs are registered alongside the state so they track it edge-for-edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_req_ab  <= 1'b0;
      r_x       <= '0;
      r_x_valid <= 1'b0;
    end else if (HALT) begin
      r_state   <= ST_IDLE;
      r_req_ab  <= 1'b0;
      r_x_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_x_valid <= 1'b0;
          if (START) begin
            r_state  <= ST_REQ;
            r_req_ab <= 1'b1;
          end
        end
        ST_REQ: begin
          if (ACK) begin
            r_state  <= ST_CALC;
            r_req_ab <= 1'b0;
          end
        end
        ST_CALC: begin
          // The edge after the 8th iteration publishes the product.
          if (w_done) begin
            r_state   <= ST_OUT;
            r_x       <= w_acc;
            r_x_valid <= 1'b1;
          end
        end
        ST_OUT: begin
          r_state   <= ST_REQ;
          r_req_ab  <= 1'b1;
          r_x_valid <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_req_ab  <= 1'b0;
          r_x_valid <= 1'b0;
        end
      endcase
    end
  end

  assign REQ_AB  = r_req_ab;
  assign X       = r_x;
  assign X_VALID = r_x_valid;

endmodule

// File: tb/tb_kadai4.sv
module tb_kadai4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        HALT = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic        ACK = 1'b0;
  logic        REQ_AB;
  logic [15:0] X;
  logic        X_VALID;

  kadai4 dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .HALT    (HALT),
    .A       (A),
    .B       (B),
    .ACK     (ACK),
    .REQ_AB  (REQ_AB),
    .X       (X),
    .X_VALID (X_VALID)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] prod;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [15:0] last_x = '0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic note_fail(input string name);
    n_total++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: every X_VALID must match the oldest outstanding product, on time.
  always @(negedge CLK) begin
    if (X_VALID) begin
      if (q.size() == 0) begin
        note_fail("unexpected_x_valid");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("x_value", X, e.prod);
        chk("x_latency", cyc, e.due);
        last_x = e.prod;
      end
    end else if (q.size() > 0 && cyc > q[0].due) begin
      note_fail("missing_x_valid");
      void'(q.pop_front());
    end
  end

  // Wait for REQ_AB, optionally stall, then pulse ACK with the operands.
  task automatic do_ack(input logic [7:0] a, input logic [7:0] b, input int stall);
    int waited;
    exp_t e;
    waited = 0;
    while (REQ_AB !== 1'b1 && waited < 60) begin
      @(negedge CLK);
      waited++;
    end
    if (REQ_AB !== 1'b1) begin
      note_fail("req_ab_timeout");
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge CLK);
      chk("stall_req_ab", REQ_AB, 1);
    end
    A = a;
    B = b;
    ACK = 1'b1;
    e.prod = 16'(a) * 16'(b);
    e.due  = cyc + 10;
    q.push_back(e);
    @(negedge CLK);
    ACK = 1'b0;
    A = $urandom_range(0, 255);
    B = $urandom_range(0, 255);
    chk("req_ab_drop", REQ_AB, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (q.size() != 0) note_fail("drain_timeout");
  endtask

  task automatic start_pulse();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("start_req_ab", REQ_AB, 1);
  endtask

  logic [7:0] bnd_a[4] = '{8'hFF, 8'h00, 8'h01, 8'h80};
  logic [7:0] bnd_b[4] = '{8'hFF, 8'h37, 8'h80, 8'h02};

  initial begin
    // Reset for two cycles.
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_x", X, 0);
    chk("rst_x_valid", X_VALID, 0);
    chk("rst_req_ab", REQ_AB, 0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    chk("idle_req_ab", REQ_AB, 0);

    // Basic product, then boundary operands back to back.
    start_pulse();
    do_ack(8'h4A, 8'h5B, 0);
    drain();
    chk("basic_x", X, 16'h1A4E);
    @(negedge CLK);
    chk("basic_rereq", REQ_AB, 1);
    for (int i = 0; i < 4; i++) do_ack(bnd_a[i], bnd_b[i], 0);
    drain();
    chk("bnd_last_x", X, 16'h0100);

    // Stalled producer.
    do_ack(8'h13, 8'hC7, 5);

    // Randomized traffic with random ACK delays.
    for (int i = 0; i < 20; i++)
      do_ack(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom_range(0, 3));
    drain();

    // HALT at the 4th CALC iteration.
    do_ack(8'hAB, 8'hCD, 0);
    repeat (3) @(negedge CLK);
    HALT = 1'b1;
    q.delete();
    @(negedge CLK);
    HALT = 1'b0;
    chk("halt_req_ab", REQ_AB, 0);
    chk("halt_x_valid", X_VALID, 0);
    repeat (12) @(negedge CLK);
    chk("halt_idle_req_ab", REQ_AB, 0);
    chk("halt_x_hold", X, last_x);
    start_pulse();
    do_ack(8'h9C, 8'hE3, 0);
    drain();
    chk("halt_restart_x", X, 16'h9C * 16'hE3);

    // RST at the 4th CALC iteration.
    do_ack(8'h77, 8'h66, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    q.delete();
    @(negedge CLK);
    RST = 1'b0;
    last_x = '0;
    chk("mrst_x", X, 0);
    chk("mrst_x_valid", X_VALID, 0);
    chk("mrst_req_ab", REQ_AB, 0);
    repeat (12) @(negedge CLK);
    chk("mrst_idle_req_ab", REQ_AB, 0);
    chk("mrst_x_hold", X, 0);
    start_pulse();
    do_ack(8'h2E, 8'hF1, 1);
    drain();
    chk("mrst_restart_x", X, 16'h2E * 16'hF1);

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kadai4.md
# kadai4

Sequential 8×8 unsigned multiplier with a request/acknowledge operand interface. Once started, the block repeatedly requests an operand pair on A/B, computes X = A×B with a shift-add datapath, and presents the 16-bit product with a one-cycle valid strobe. It stops only on HALT or reset. It is a self-contained leaf block fed by an operand producer and read by a result consumer.

## Interface
- Parameters: none. Widths are fixed at 8-bit operands and a 16-bit product.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset. One clock; reset is synchronous and active-high (CLK, RST).
- START  in  1  level; while in IDLE, a high START begins operation.
- HALT  in  1  level; abort and return to IDLE. Has priority over everything except RST.
- A  in  8  operand A, unsigned, valid when ACK=1.
- B  in  8  operand B, unsigned, valid when ACK=1.
- ACK  in  1  producer acknowledge; A/B are captured on an edge where ACK=1 and REQ_AB=1.
- REQ_AB  out  1  operand request.
- X  out  16  product register; holds the last completed result.
- X_VALID  out  1  one-cycle strobe marking a new X.

## Operation
- The FSM has four states: IDLE, REQ, CALC, OUT.
- **IDLE**
  - REQ_AB=0 and X_VALID=0.
  - If START=1 and HALT=0, go to REQ.
- **REQ**
  - REQ_AB=1.
  - On an edge with ACK=1, capture A into the multiplicand register and B into the multiplier register. Clear the accumulator and the bit counter, then go to CALC.
  - ACK=0 means wait indefinitely.
  - ACK outside REQ is ignored.
- **CALC**
  - Runs exactly 8 iterations, LSB first. For each iteration:
    - If the multiplier LSB is 1, add the multiplicand, zero-extended and shifted by the counter position, to the 16-bit accumulator.
    - Shift the multiplier right by 1 and increment the counter.
  - After the 8th iteration, go to OUT.
  - The final accumulator value is the exact unsigned product: 0..0xFE01, with no overflow.
- **OUT**
  - X ← accumulator and X_VALID=1 for this single cycle.
  - Next state is REQ: operation is continuous, and START is not re-checked.
- **HALT=1 in any state**
  - Next state is IDLE and the pending computation is discarded.
  - X keeps its previous value; X_VALID and REQ_AB are 0 from the next cycle.
- **RST=1**
  - All registers clear: state=IDLE, X=0, X_VALID=0, REQ_AB=0, accumulator and counter = 0.
  - RST asserted mid-operation behaves identically.
- **Output registration**
  - All outputs are registered; there are no combinational paths from inputs to outputs.
- **Simultaneous inputs**
  - START and HALT both high in IDLE: stay in IDLE.
  - ACK and HALT both high in REQ: HALT wins, and the operands are not captured.

## Timing
- **Reset state:** after the edge at which RST=1 is sampled, every output is 0.
- **Start:** START sampled high in IDLE at edge n → REQ_AB=1 after edge n.
- **Operand capture:** ACK sampled high at edge m while in REQ:
  - REQ_AB=0 after edge m.
  - The 8 CALC iterations occur at edges m+1..m+8.
  - X is updated and X_VALID=1 after edge m+9.
  - X_VALID=0 and REQ_AB=1 after edge m+10.
- **Throughput:** one product per 10 cycles plus the ACK wait.
- **ACK protocol:** ACK is a one-cycle pulse. ACK held high beyond the capture edge is ignored because the FSM is no longer in REQ. ACK still high when REQ re-asserts will capture immediately.

## Structure
- Package kadai4_pkg holds:
  - the state enum (IDLE, REQ, CALC, OUT);
  - OPW=8 and RESW=16 width constants;
  - ITERS=8.
- Sub-module kadai4_mul8 holds the shift-add datapath:
  - operand registers, accumulator and counter;
  - inputs load, step and clear; output done.
- The top level holds the FSM, the handshake logic and the X/X_VALID registers.

## Test plan
- **Reset:** RST high for 2 cycles → X=0, X_VALID=0, REQ_AB=0. IDLE holds while START=0.
- **Basic product:** START=1, then on REQ_AB answer a one-cycle ACK with A=0x4A, B=0x5B.
  - REQ_AB drops the next cycle.
  - After 9 more edges, X=0x1A4E with a single-cycle X_VALID.
  - REQ_AB re-asserts.
- **Boundary operands:**
  - 0xFF×0xFF → 0xFE01.
  - 0x00×0x37 → 0x0000.
  - 0x01×0x80 → 0x0080.
  - 0x80×0x02 → 0x0100.
- **Stalled producer:** hold ACK=0 for 5 cycles in REQ → REQ_AB stays 1 and no X_VALID. A later ACK completes normally.
- **HALT mid-CALC:** HALT at the 4th iteration →
  - IDLE next cycle;
  - no X_VALID;
  - X retains the previous product;
  - restart with START gives the correct new result.
- **RST mid-CALC:** all outputs are 0 on the next cycle, and the FSM stays in IDLE until START.
